weight_fetch_sequencer: RTL and testbench

- Sequencer between the weight ROM and the neuron MAC stage.
- On `start`, it walks a layer's weights in ROM order: neuron-major, input-minor.
- It drives the ROM's `address`/`enable` and registers each returned word.
- It presents the words to the MAC as a valid/ready stream, tagged with neuron and input indices and last flags.

---
 rtl/weight_fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_weight_fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_sequencer.sv
// Weight fetch sequencer: walks a layer's weights in ROM order (neuron-major,
// input-minor), reads them through a combinational ROM and presents each word
// to the MAC stage as a tagged valid/ready beat held in a single output register.
module weight_fetch_sequencer #(
  parameter int DATA_BUS_WIDTH    = 8,
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int COUNT_WIDTH       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDRESS_BUS_WIDTH-1:0] base_address,
  input  logic [COUNT_WIDTH-1:0]       num_neurons,
  input  logic [COUNT_WIDTH-1:0]       num_inputs,
  output logic                         busy,
  output logic                         done,
  output logic [ADDRESS_BUS_WIDTH-1:0] rom_address,
  output logic                         rom_enable,
  input  logic [DATA_BUS_WIDTH-1:0]    rom_data,
  output logic [DATA_BUS_WIDTH-1:0]    w_data,
  output logic                         w_valid,
  input  logic                         w_ready,
  output logic [COUNT_WIDTH-1:0]       w_neuron,
  output logic [COUNT_WIDTH-1:0]       w_input,
  output logic                         w_last_input,
  output logic                         w_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Layer shape latched at start; fetch-side position counters.
  logic [COUNT_WIDTH-1:0]       r_num_neurons;
  logic [COUNT_WIDTH-1:0]       r_num_inputs;
  logic [COUNT_WIDTH-1:0]       r_fetch_neuron;
  logic [COUNT_WIDTH-1:0]       r_fetch_input;
  logic [ADDRESS_BUS_WIDTH-1:0] r_rom_address;

  // Output register (one beat deep).
  logic [DATA_BUS_WIDTH-1:0]    r_data;
  logic                         r_valid;
  logic [COUNT_WIDTH-1:0]       r_neuron;
  logic [COUNT_WIDTH-1:0]       r_input;
  logic                         r_last_input;
  logic                         r_last;

  logic w_start_go;
  logic w_start_empty;
  logic w_fetch;
  logic w_handshake;
  logic w_fetch_last_input;
  logic w_fetch_final;

  // Decode of the current fetch position and the start request.
  always_comb begin
    w_handshake        = r_valid & w_ready;
    w_fetch_last_input = (r_fetch_input == r_num_inputs - COUNT_WIDTH'(1));
    w_fetch_final      = w_fetch_last_input &&
                         (r_fetch_neuron == r_num_neurons - COUNT_WIDTH'(1));
    w_start_empty      = (num_neurons == '0) || (num_inputs == '0);
    w_start_go         = (r_state == S_IDLE) && start && !w_start_empty;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic, fetch strobe and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = w_start_empty ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        // Refill when the output register is empty or is being drained now.
        w_fetch = !r_valid || w_handshake;
        if (w_fetch && w_fetch_final) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_handshake && r_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Layer latch, address/index walk and output beat register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_neurons  <= '0;
      r_num_inputs   <= '0;
      r_fetch_neuron <= '0;
      r_fetch_input  <= '0;
      r_rom_address  <= '0;
      r_data         <= '0;
      r_valid        <= 1'b0;
      r_neuron       <= '0;
      r_input        <= '0;
      r_last_input   <= 1'b0;
      r_last         <= 1'b0;
    end else begin
      if (w_start_go) begin
        r_num_neurons  <= num_neurons;
        r_num_inputs   <= num_inputs;
        r_fetch_neuron <= '0;
        r_fetch_input  <= '0;
        r_rom_address  <= base_address;
      end
      if (w_fetch) begin
        r_data       <= rom_data;
        r_neuron     <= r_fetch_neuron;
        r_input      <= r_fetch_input;
        r_last_input <= w_fetch_last_input;
        r_last       <= w_fetch_final;
        r_valid      <= 1'b1;
        // Linear index advances by one per weight, so the address simply
        // increments (wrapping modulo the bus width); it stays on the final
        // address once the layer has been fully fetched.
        if (!w_fetch_final) begin
          r_rom_address <= r_rom_address + ADDRESS_BUS_WIDTH'(1);
          if (w_fetch_last_input) begin
            r_fetch_input  <= '0;
            r_fetch_neuron <= r_fetch_neuron + COUNT_WIDTH'(1);
          end else begin
            r_fetch_input <= r_fetch_input + COUNT_WIDTH'(1);
          end
        end
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rom_address  = r_rom_address;
    rom_enable   = w_fetch;
    w_data       = r_data;
    w_valid      = r_valid;
    w_neuron     = r_neuron;
    w_input      = r_input;
    w_last_input = r_last_input;
    w_last       = r_last;
  end

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Bench for weight_fetch_sequencer: ROM model mem[i] = i[7:0], expected beat
// and fetch-address lists built from the layer shape with plain arithmetic.
module tb_weight_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_address;
  logic [7:0]  num_neurons;
  logic [7:0]  num_inputs;
  logic        busy;
  logic        done;
  logic [15:0] rom_address;
  logic        rom_enable;
  logic [7:0]  rom_data;
  logic [7:0]  w_data;
  logic        w_valid;
  logic        w_ready;
  logic [7:0]  w_neuron;
  logic [7:0]  w_input;
  logic        w_last_input;
  logic        w_last;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] n;
    logic [7:0] i;
    logic       li;
    logic       l;
  } beat_t;

  weight_fetch_sequencer #(
    .DATA_BUS_WIDTH   (8),
    .ADDRESS_BUS_WIDTH(16),
    .COUNT_WIDTH      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_address(base_address),
    .num_neurons (num_neurons),
    .num_inputs  (num_inputs),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_enable  (rom_enable),
    .rom_data    (rom_data),
    .w_data      (w_data),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_neuron    (w_neuron),
    .w_input     (w_input),
    .w_last_input(w_last_input),
    .w_last      (w_last)
  );

  // ROM: mem[i] = i[7:0]. When disabled the bus floats; drive a distinct
  // pattern instead so a capture without enable shows up as wrong data.
  assign rom_data = rom_enable ? rom_address[7:0] : ~rom_address[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_en"},    rom_enable, 0);
    check({tag, "_valid"}, w_valid, 0);
    check({tag, "_li"},    w_last_input, 0);
    check({tag, "_last"},  w_last, 0);
    check({tag, "_addr"},  rom_address, 0);
    check({tag, "_data"},  w_data, 0);
    check({tag, "_neur"},  w_neuron, 0);
    check({tag, "_inp"},   w_input, 0);
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0 repeating; 2: random.
  task automatic run_layer(input logic [15:0] base, input logic [7:0] nn,
                           input logic [7:0] ni, input int mode, input bit restart);
    beat_t       exp_q[$];
    logic [15:0] addr_q[$];
    beat_t       prev;
    beat_t       b;
    int          total;
    int          c;
    int          hs;
    int          last_hs_c;
    bit          prev_stall;
    bit          fin;
    total = int'(nn) * int'(ni);
    for (int n = 0; n < int'(nn); n++) begin
      for (int i = 0; i < int'(ni); i++) begin
        logic [15:0] a;
        a      = base + 16'(n * int'(ni) + i);
        b.data = a[7:0];
        b.n    = 8'(n);
        b.i    = 8'(i);
        b.li   = (i == int'(ni) - 1);
        b.l    = (n == int'(nn) - 1) && (i == int'(ni) - 1);
        exp_q.push_back(b);
        addr_q.push_back(a);
      end
    end

    @(negedge clk);
    start        = 1'b1;
    base_address = base;
    num_neurons  = nn;
    num_inputs   = ni;
    w_ready      = 1'b0;
    c = 0; hs = 0; last_hs_c = -1; prev_stall = 1'b0; fin = 1'b0; prev = '0;

    while (!fin) begin
      @(negedge clk);
      c++;
      start        = restart && (c == 3);
      base_address = 16'($urandom);
      num_neurons  = 8'($urandom);
      num_inputs   = 8'($urandom);
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = (c % 3 == 1);
        default: w_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (c == 1 && total > 0) check("first_enable", rom_enable, 1);
      if (c == 2 && total > 0) check("first_valid", w_valid, 1);
      if (prev_stall) begin
        check("stall_data",   w_data, prev.data);
        check("stall_neuron", w_neuron, prev.n);
        check("stall_input",  w_input, prev.i);
        check("stall_li",     w_last_input, prev.li);
        check("stall_last",   w_last, prev.l);
      end
      if (w_valid && !w_ready) check("stall_no_fetch", rom_enable, 0);
      if (rom_enable) begin
        if (addr_q.size() == 0) check("extra_fetch", rom_enable, 0);
        else                    check("rom_address", rom_address, addr_q.pop_front());
      end
      if (done) begin
        check("done_busy", busy, 0);
        check("done_valid", w_valid, 0);
        check("beat_count", hs, total);
        check("fetches_left", addr_q.size(), 0);
        if (total == 0) check("done_cycle_empty", c, 1);
        else            check("done_after_last", c, last_hs_c + 1);
        if (mode == 0 && total > 0) check("done_cycle_full_rate", c, total + 2);
        fin = 1'b1;
      end else begin
        check("busy", busy, total > 0);
      end
      if (w_valid && w_ready) begin
        hs++;
        last_hs_c = c;
        if (exp_q.size() == 0) check("extra_beat", w_valid, 0);
        else begin
          b = exp_q.pop_front();
          check("beat_data",   w_data, b.data);
          check("beat_neuron", w_neuron, b.n);
          check("beat_input",  w_input, b.i);
          check("beat_li",     w_last_input, b.li);
          check("beat_last",   w_last, b.l);
        end
      end
      prev_stall = w_valid && !w_ready;
      prev       = {w_data, w_neuron, w_input, w_last_input, w_last};
      if (!fin && c >= 500) begin
        check("timeout_done", done, 1);
        fin = 1'b1;
      end
    end

    @(negedge clk);
    start = 1'b0;
    #1;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_en", rom_enable, 0);
    check("post_valid", w_valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_address = '0; num_neurons = '0;
    num_inputs = '0; w_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    run_layer(16'h0010, 8'd2, 8'd3, 0, 1'b0);
    run_layer(16'h0010, 8'd2, 8'd3, 1, 1'b0);
    run_layer(16'hFFFE, 8'd1, 8'd4, 0, 1'b0);
    run_layer(16'h0200, 8'd0, 8'd5, 0, 1'b0);
    run_layer(16'h0300, 8'd4, 8'd0, 0, 1'b0);
    run_layer(16'h0100, 8'd3, 8'd3, 0, 1'b1);
    run_layer(16'h0500, 8'd3, 8'd1, 2, 1'b0);
    for (int k = 0; k < 6; k++)
      run_layer(16'($urandom), 8'($urandom_range(1, 4)), 8'($urandom_range(1, 4)), 2, 1'b0);

    // Reset in the middle of a 3x3 layer with a beat pending.
    @(negedge clk);
    start = 1'b1; base_address = 16'h0040; num_neurons = 8'd3; num_inputs = 8'd3;
    w_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    w_ready = 1'b0;
    #1;
    check("midrst_pending_valid", w_valid, 1);
    check("midrst_pending_input", w_input, 2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_cleared("midrst");
    rst = 1'b0;
    w_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("after_rst_valid", w_valid, 0);
      check("after_rst_en", rom_enable, 0);
    end
    run_layer(16'h1234, 8'd1, 8'd1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
